weight_pad_sched: RTL
=====================

Name: weight_pad_sched

Overview:
- Controller that sequences one PE's weight scratchpad loader. It sits between the global-buffer weight stream and the loader's FIFO/scratchpad pair.
- Issues the load-start pulse, then streams exactly weight_num words into the loader FIFO under back-pressure.
- In parallel, generates scratchpad read addresses for the PE. Each of pixel_num passes sweeps addresses 0..weight_num-1.
- First-pass reads never overtake writes, and the engine signals completion.

Parameters:
- DATA_WIDTH, 16, weight word width.
- ADDRESSWIDTH_W_PAD, 8, scratchpad address and weight-count width.
- ADDRESSWIDTH_F_PAD, 8, pixel-count width.
- SETTLE_CYC, 10, cycles after the last accepted push before the full scratchpad is treated as written. Covers FIFO depth plus the 2-cycle loader write path.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- cfg_start  in  1  one-cycle job start; ignored while busy
- cfg_weight_num  in  ADDRESSWIDTH_W_PAD  weights per filter; sampled on cfg_start
- cfg_pixel_num  in  ADDRESSWIDTH_F_PAD  read passes; sampled on cfg_start
- gb_data  in  DATA_WIDTH  weight word from global buffer
- gb_valid  in  1  gb_data valid
- gb_ready  out  1  word accepted when gb_valid & gb_ready
- weight_load_start  out  1  pulse to loader
- weight_num  out  ADDRESSWIDTH_W_PAD  registered copy of cfg_weight_num
- weight_in  out  DATA_WIDTH  equals gb_data
- weight_in_en  out  1  gb_valid & gb_ready
- fifo_full  in  1  loader FIFO full
- pad_data_ready  in  1  loader: write pointer is more than 3 ahead of base_address
- raddra_filter  out  ADDRESSWIDTH_W_PAD  scratchpad read address
- base_address  out  ADDRESSWIDTH_W_PAD  equals raddra_filter
- pe_stall  in  1  PE cannot take a weight this cycle
- w_valid  out  1  weight_out from scratchpad is valid this cycle (1-cycle RAM latency)
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end

Behaviour:
- Clock and reset: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: all outputs 0, FSM=IDLE, all counters 0. A reset mid-job aborts the job with no done pulse. The loader must be reset by the same rst_n.
- IDLE:
  - cfg_start with either count equal to 0 -> DONE next cycle, no weight_load_start.
  - otherwise latch both counts -> START.
- START: weight_load_start=1 for exactly one cycle -> RUN.
- RUN, write side:
  - gb_ready = !fifo_full & (wr_cnt < weight_num).
  - wr_cnt increments on each accepted word.
  - Once wr_cnt==weight_num, a settle counter counts SETTLE_CYC cycles, then sets loaded=1.
- RUN, read side:
  - read_ok = !pe_stall & (loaded | pad_data_ready | pix_cnt!=0).
  - When read_ok: issue raddra_filter=rd_addr and register w_valid=1 for the next cycle. On rd_addr==weight_num-1, wrap rd_addr to 0 and increment pix_cnt; otherwise increment rd_addr.
  - A read issued with rd_addr==weight_num-1 and pix_cnt==pixel_num-1 is the last read -> DRAIN.
- DRAIN:
  - Wait 1 cycle (last w_valid), then also wait until loaded=1. This guarantees the write side is complete before the next job.
  - Then -> DONE.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- busy=1 in START, RUN and DRAIN.
- Write and read sides run concurrently in RUN. Simultaneous push and read in one cycle is legal.
- Counters are compared at full width with no overflow. weight_num=1 is legal: pass k reads address 0.
- Words offered on gb_valid outside RUN, or after wr_cnt==weight_num, are not accepted (gb_ready=0).

Decomposition:
- Shared package (pe_pkg): FSM state encodings IDLE/START/RUN/DRAIN/DONE, the SETTLE_CYC default, and the scratchpad RAM read-latency constant (1).
- One natural sub-module: weight_rd_addr_gen, holding rd_addr/pix_cnt wrap logic, w_valid pipeline and last-read detection. It takes enable=read_ok and returns last_issued.

Test Plan:
- Basic job: weight_num=6, pixel_num=2, gb_valid always 1, fifo_full=0, pe_stall=0, loader model attached.
  - exactly 6 weight_in_en pulses, one weight_load_start, 12 w_valid pulses with addresses 0..5,0..5, data matches pushed words.
  - done pulses once.
- Back-pressure: fifo_full held high for 5 cycles mid-stream -> gb_ready=0 throughout, no word lost or duplicated. First-pass reads never issue while pad_data_ready=0 and loaded=0.
- Stall: pe_stall toggled every other cycle during the second pass -> raddra_filter holds while stalled, and w_valid count still equals 12.
- Zero counts: cfg_start with weight_num=0 (then again with pixel_num=0) -> done 2 cycles after cfg_start, no weight_load_start, gb_ready stays 0.
- Edge counts:
  - weight_num=1, pixel_num=3 -> three reads of address 0, issued once loaded.
  - cfg_start asserted while busy -> ignored, counts unchanged.
- Reset abort: assert rst_n=0 in RUN after 3 pushes -> all outputs 0 immediately. A new job after release completes correctly.

Source files
------------

// File: rtl/weight_pad_sched_pkg.sv
// Shared types and constants for the PE weight scratchpad sequencer.
package weight_pad_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int SETTLE_CYC_DEF = 10;
  localparam int RAM_RD_LAT     = 1;

  function automatic logic is_busy_state(input state_e s);
    return (s == ST_START) || (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/weight_pad_sched_if.sv
// Global-buffer stream, loader FIFO/scratchpad and PE-side signals of one weight pad.
interface weight_pad_sched_if #(
  parameter int DATA_WIDTH         = 16,
  parameter int ADDRESSWIDTH_W_PAD = 8
);
  logic [DATA_WIDTH-1:0]         gb_data;
  logic                          gb_valid;
  logic                          gb_ready;
  logic                          weight_load_start;
  logic [ADDRESSWIDTH_W_PAD-1:0] weight_num;
  logic [DATA_WIDTH-1:0]         weight_in;
  logic                          weight_in_en;
  logic                          fifo_full;
  logic                          pad_data_ready;
  logic [ADDRESSWIDTH_W_PAD-1:0] raddra_filter;
  logic [ADDRESSWIDTH_W_PAD-1:0] base_address;
  logic                          pe_stall;
  logic                          w_valid;

  modport master (
    input  gb_data, gb_valid, fifo_full, pad_data_ready, pe_stall,
    output gb_ready, weight_load_start, weight_num, weight_in, weight_in_en,
           raddra_filter, base_address, w_valid
  );

  modport slave (
    output gb_data, gb_valid, fifo_full, pad_data_ready, pe_stall,
    input  gb_ready, weight_load_start, weight_num, weight_in, weight_in_en,
           raddra_filter, base_address, w_valid
  );
endinterface

// File: rtl/weight_pad_sched_rd_addr_gen.sv
// Scratchpad read-address sweeper: pixel_num passes over 0..weight_num-1,
// with the data-valid flag delayed by the RAM read latency.
module weight_rd_addr_gen
  import weight_pad_sched_pkg::*;
#(
  parameter int AW = 8,
  parameter int FW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          enable_i,
  input  logic [AW-1:0] weight_num_i,
  input  logic [FW-1:0] pixel_num_i,
  output logic [AW-1:0] rd_addr_o,
  output logic [FW-1:0] pix_cnt_o,
  output logic          w_valid_o,
  output logic          last_issued_o
);
  logic [AW-1:0]         rd_addr_q;
  logic [FW-1:0]         pix_cnt_q;
  logic [RAM_RD_LAT-1:0] vld_q;
  logic                  addr_last_s;
  logic                  pix_last_s;

  assign addr_last_s   = (rd_addr_q == (weight_num_i - AW'(1)));
  assign pix_last_s    = (pix_cnt_q == (pixel_num_i - FW'(1)));
  assign last_issued_o = enable_i && addr_last_s && pix_last_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= AW'(0);
      pix_cnt_q <= FW'(0);
    end else if (clear_i) begin
      rd_addr_q <= AW'(0);
      pix_cnt_q <= FW'(0);
    end else if (enable_i) begin
      if (addr_last_s) begin
        rd_addr_q <= AW'(0);
        pix_cnt_q <= pix_cnt_q + FW'(1);
      end else begin
        rd_addr_q <= rd_addr_q + AW'(1);
      end
    end
  end

  // Valid follows the issued read by the RAM latency so it lines up with weight_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= {RAM_RD_LAT{1'b0}};
    end else begin
      vld_q[0] <= enable_i;
      for (int i = 1; i < RAM_RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign rd_addr_o = rd_addr_q;
  assign pix_cnt_o = pix_cnt_q;
  assign w_valid_o = vld_q[RAM_RD_LAT-1];
endmodule

// File: rtl/weight_pad_sched.sv
// Weight scratchpad sequencer for one PE: streams a filter into the loader FIFO
// and, concurrently, sweeps scratchpad read addresses once per output pixel.
module weight_pad_sched
  import weight_pad_sched_pkg::*;
#(
  parameter int DATA_WIDTH         = 16,
  parameter int ADDRESSWIDTH_W_PAD = 8,
  parameter int ADDRESSWIDTH_F_PAD = 8,
  parameter int SETTLE_CYC         = SETTLE_CYC_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_start_i,
  input  logic [ADDRESSWIDTH_W_PAD-1:0] cfg_weight_num_i,
  input  logic [ADDRESSWIDTH_F_PAD-1:0] cfg_pixel_num_i,
  weight_pad_sched_if.master            bus,
  output logic                          busy_o,
  output logic                          done_o
);
  localparam int AW = ADDRESSWIDTH_W_PAD;
  localparam int FW = ADDRESSWIDTH_F_PAD;
  localparam int SW = $clog2(SETTLE_CYC + 1);

  state_e                state_q, state_d;
  logic [AW-1:0]         wn_q, wr_cnt_q;
  logic [FW-1:0]         pn_q;
  logic [SW-1:0]         settle_q;
  logic                  loaded_q, drain_seen_q, busy_q, done_q, load_start_q;
  logic                  cfg_zero_s, job_go_s, gb_ready_s, push_s, settle_en_s;
  logic                  read_ok_s, last_issued_s, w_valid_s;
  logic [AW-1:0]         rd_addr_s;
  logic [FW-1:0]         pix_cnt_s;
  logic [DATA_WIDTH-1:0] weight_s;

  assign cfg_zero_s = (cfg_weight_num_i == AW'(0)) || (cfg_pixel_num_i == FW'(0));
  assign job_go_s   = (state_q == ST_IDLE) && cfg_start_i && !cfg_zero_s;

  assign gb_ready_s  = (state_q == ST_RUN) && !bus.fifo_full && (wr_cnt_q < wn_q);
  assign push_s      = bus.gb_valid && gb_ready_s;
  assign settle_en_s = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                       (wr_cnt_q == wn_q) && !loaded_q;
  // After the first pass every address is already in the pad, so only pass 0 is gated.
  assign read_ok_s   = (state_q == ST_RUN) && !bus.pe_stall &&
                       (loaded_q || bus.pad_data_ready || (pix_cnt_s != FW'(0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start_i) begin
          state_d = cfg_zero_s ? ST_DONE : ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (last_issued_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      // Hold until the final w_valid is out and the write side has settled.
      ST_DRAIN: begin
        if (drain_seen_q && loaded_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wn_q     <= AW'(0);
      pn_q     <= FW'(0);
      wr_cnt_q <= AW'(0);
      settle_q <= SW'(0);
      loaded_q <= 1'b0;
    end else if (job_go_s) begin
      wn_q     <= cfg_weight_num_i;
      pn_q     <= cfg_pixel_num_i;
      wr_cnt_q <= AW'(0);
      settle_q <= SW'(0);
      loaded_q <= 1'b0;
    end else begin
      if (push_s) begin
        wr_cnt_q <= wr_cnt_q + AW'(1);
      end
      if (settle_en_s) begin
        if (settle_q == SW'(SETTLE_CYC - 1)) begin
          loaded_q <= 1'b1;
        end else begin
          settle_q <= settle_q + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      load_start_q <= 1'b0;
      done_q       <= 1'b0;
      drain_seen_q <= 1'b0;
    end else begin
      busy_q       <= is_busy_state(state_d);
      load_start_q <= (state_d == ST_START);
      done_q       <= (state_q == ST_DONE);
      drain_seen_q <= (state_q == ST_DRAIN);
    end
  end

  weight_rd_addr_gen #(.AW(AW), .FW(FW)) u_rd_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (job_go_s),
    .enable_i     (read_ok_s),
    .weight_num_i (wn_q),
    .pixel_num_i  (pn_q),
    .rd_addr_o    (rd_addr_s),
    .pix_cnt_o    (pix_cnt_s),
    .w_valid_o    (w_valid_s),
    .last_issued_o(last_issued_s)
  );

  assign weight_s              = bus.gb_data;
  assign bus.weight_in         = weight_s;
  assign bus.gb_ready          = gb_ready_s;
  assign bus.weight_in_en      = push_s;
  assign bus.weight_load_start = load_start_q;
  assign bus.weight_num        = wn_q;
  assign bus.raddra_filter     = rd_addr_s;
  assign bus.base_address      = rd_addr_s;
  assign bus.w_valid           = w_valid_s;
  assign busy_o                = busy_q;
  assign done_o                = done_q;
endmodule
